// File: rtl/tpfu_sequencer.sv
// ============================================================================
// tpfu_sequencer
// ----------------------------------------------------------------------------
// Control block for the single-FU temporally programmed functional unit.
//
// One run has four phases:
//   1. IDLE  : the host may (re)write the program memory. The first accepted
//              operand beat starts a run.
//   2. LOAD  : operand beats stream into the 64x16 register file at
//              consecutive addresses. At most 64 beats are taken; later
//              beats are held off with o_din_ready=0, never dropped and
//              never wrapped.
//   3. EXEC  : pmem[0 .. prog_len-1] is issued one instruction per cycle on
//              o_inst / o_inst_v.
//   4. DRAIN : waits until the ALU latency pipes are empty, pulses o_done for
//              one cycle and returns to IDLE.
//
// Operand handshake (valid/ready):
//   A beat transfers on every rising clk edge where i_din_valid and
//   o_din_ready are both high. o_din_ready does not depend on i_din_valid,
//   so the source may hold i_din/i_din_valid until it observes the transfer.
//   A held beat is neither lost nor duplicated. Only IDLE and LOAD (below 64
//   words) ever assert o_din_ready.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_prog_we      program memory write strobe (honoured only in IDLE)
//   i_prog_addr    program memory write address
//   i_prog_wdata   instruction word to write
//   i_prog_len     number of instructions to issue (0..16), sampled when LOAD
//                  ends
//   i_din          operand stream data
//   i_din_valid    operand stream valid
//   o_din_ready    operand stream ready
//   o_rf_we        register file write enable  (combinational)
//   o_rf_waddr     register file write address (combinational)
//   o_rf_wdata     register file write data    (combinational)
//   o_inst         issued instruction (registered)
//   o_inst_v       o_inst is valid this cycle
//   o_wb_addr      dst field of the instruction whose result is valid now
//   o_wb_imm_sel   inst[23] of that instruction
//   o_dout_v       ALU result valid, PIPE_LAT cycles after its o_inst_v
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse when the program has fully drained
//   o_state        current FSM state (0=IDLE 1=LOAD 2=EXEC 3=DRAIN), debug
//
// Instruction layout: opcode[23:18] dst[17:12] src1[11:6] src2/imm[5:0].
// ============================================================================
module tpfu_sequencer #(
    parameter int PC_BITS      = 4,
    parameter int INST_W       = 24,
    parameter int RF_ADDR_BITS = 6,
    parameter int PIPE_LAT     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_prog_we,
    input  logic [PC_BITS-1:0]      i_prog_addr,
    input  logic [INST_W-1:0]       i_prog_wdata,
    input  logic [PC_BITS:0]        i_prog_len,
    input  logic [15:0]             i_din,
    input  logic                    i_din_valid,
    output logic                    o_din_ready,
    output logic                    o_rf_we,
    output logic [RF_ADDR_BITS-1:0] o_rf_waddr,
    output logic [15:0]             o_rf_wdata,
    output logic [INST_W-1:0]       o_inst,
    output logic                    o_inst_v,
    output logic [RF_ADDR_BITS-1:0] o_wb_addr,
    output logic                    o_wb_imm_sel,
    output logic                    o_dout_v,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [1:0]              o_state
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int PC_W      = PC_BITS + 1;       // counts 0..2**PC_BITS
    localparam int CNT_W     = RF_ADDR_BITS + 1;  // counts 0..2**RF_ADDR_BITS
    localparam int PMEM_D    = 2 ** PC_BITS;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_BITS;
    localparam int DST_MSB   = INST_W - 7;        // dst sits just below opcode
    localparam int DST_LSB   = DST_MSB - RF_ADDR_BITS + 1;

    localparam logic [CNT_W-1:0] RF_FULL = CNT_W'(RF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                  r_state;
    logic [CNT_W-1:0]        r_count;     // words loaded so far in this burst
    logic [PC_W-1:0]         r_pc;        // next instruction to issue
    logic [PC_W-1:0]         r_len;       // program length latched for EXEC
    logic [INST_W-1:0]       r_inst;
    logic                    r_inst_v;

    logic [INST_W-1:0]       r_pmem [PMEM_D];

    // ALU latency pipes; stage PIPE_LAT-1 drives the outputs.
    logic [PIPE_LAT-1:0]     r_v_pipe;
    logic [PIPE_LAT-1:0]     r_imm_pipe;
    logic [RF_ADDR_BITS-1:0] r_dst_pipe [PIPE_LAT];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    state_t                  w_next_state;
    logic                    w_din_ready;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_done;
    logic                    w_pipe_empty;
    logic                    w_load_end;
    logic [PC_W-1:0]         w_pc_next;
    logic [RF_ADDR_BITS-1:0] w_dst;

    assign w_accept  = i_din_valid & w_din_ready;
    assign w_pc_next = r_pc + PC_W'(1);
    assign w_dst     = r_inst[DST_MSB:DST_LSB];

    // Nothing in flight: no instruction presented this cycle and every
    // latency stage, including the one driving o_dout_v, is empty.
    assign w_pipe_empty = !r_inst_v && (r_v_pipe == '0);

    // LOAD ends on the first cycle without a transfer.
    assign w_load_end = (r_state == S_LOAD) && !w_accept;

    always_comb begin
        w_next_state = r_state;
        w_din_ready  = 1'b0;
        w_issue      = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_din_ready = 1'b1;
                if (i_din_valid) begin
                    w_next_state = S_LOAD;
                end
            end

            S_LOAD: begin
                // Full register file: hold the source off instead of wrapping.
                w_din_ready = (r_count != RF_FULL);
                if (!(i_din_valid && w_din_ready)) begin
                    // An empty program has nothing to issue, so the EXEC
                    // cycle is skipped and the run drains immediately.
                    if (i_prog_len == '0) begin
                        w_next_state = S_DRAIN;
                    end else begin
                        w_next_state = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                if (r_pc < r_len) begin
                    w_issue = 1'b1;
                end
                // Leave on the cycle that issues the last instruction; its
                // o_inst_v still appears on the first DRAIN cycle.
                if (w_pc_next >= r_len) begin
                    w_next_state = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (w_pipe_empty) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Load counter, program counter, program length, issue register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_pc     <= '0;
            r_len    <= '0;
            r_inst   <= '0;
            r_inst_v <= 1'b0;
        end else begin
            // The count is already 0 in IDLE, so the first beat writes
            // address 0 and leaves the count at 1.
            if (w_done) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end

            if (w_load_end) begin
                r_len <= i_prog_len;
            end

            if (w_done) begin
                r_pc <= '0;
            end else if (w_issue) begin
                r_pc <= w_pc_next;
            end

            // o_inst keeps the last issued word; o_inst_v qualifies it.
            if (w_issue) begin
                r_inst <= r_pmem[r_pc[PC_BITS-1:0]];
            end
            r_inst_v <= w_issue;
        end
    end

    // ------------------------------------------------------------------------
    // Program memory: no reset, so a program survives a reset. Host writes
    // only land while the sequencer is idle, so a running program can never
    // be modified underneath itself.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_prog_we && (r_state == S_IDLE)) begin
            r_pmem[i_prog_addr] <= i_prog_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // ALU latency pipes. They shift every cycle and are cleared only by
    // reset; a completed run always leaves them empty, because DRAIN waits
    // for that before releasing the FSM.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v_pipe   <= '0;
            r_imm_pipe <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_dst_pipe[i] <= '0;
            end
        end else begin
            r_v_pipe[0]   <= r_inst_v;
            r_imm_pipe[0] <= r_inst[INST_W-1];
            r_dst_pipe[0] <= w_dst;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_v_pipe[i]   <= r_v_pipe[i-1];
                r_imm_pipe[i] <= r_imm_pipe[i-1];
                r_dst_pipe[i] <= r_dst_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_din_ready  = w_din_ready;
    assign o_rf_we      = w_accept;
    assign o_rf_waddr   = r_count[RF_ADDR_BITS-1:0];
    assign o_rf_wdata   = i_din;
    assign o_inst       = r_inst;
    assign o_inst_v     = r_inst_v;
    assign o_wb_addr    = r_dst_pipe[PIPE_LAT-1];
    assign o_wb_imm_sel = r_imm_pipe[PIPE_LAT-1];
    assign o_dout_v     = r_v_pipe[PIPE_LAT-1];
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = w_done;
    assign o_state      = r_state;

endmodule

// File: tb/tb_tpfu_sequencer.sv
// Testbench for tpfu_sequencer: directed runs with a scoreboard for register
// file writes, issued instructions and write-back tags, plus per-run timing.
module tb_tpfu_sequencer;

  localparam int PC_BITS      = 4;
  localparam int INST_W       = 24;
  localparam int RF_ADDR_BITS = 6;
  localparam int PIPE_LAT     = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------- DUT
  logic                    prog_we;
  logic [PC_BITS-1:0]      prog_addr;
  logic [INST_W-1:0]       prog_wdata;
  logic [PC_BITS:0]        prog_len;
  logic [15:0]             din;
  logic                    din_valid;
  logic                    din_ready;
  logic                    rf_we;
  logic [RF_ADDR_BITS-1:0] rf_waddr;
  logic [15:0]             rf_wdata;
  logic [INST_W-1:0]       inst;
  logic                    inst_v;
  logic [RF_ADDR_BITS-1:0] wb_addr;
  logic                    wb_imm_sel;
  logic                    dout_v;
  logic                    busy;
  logic                    done;
  logic [1:0]              state_dbg;

  tpfu_sequencer #(
    .PC_BITS(PC_BITS), .INST_W(INST_W), .RF_ADDR_BITS(RF_ADDR_BITS), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_wdata(prog_wdata),
    .i_prog_len(prog_len), .i_din(din), .i_din_valid(din_valid),
    .o_din_ready(din_ready), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_inst(inst), .o_inst_v(inst_v), .o_wb_addr(wb_addr), .o_wb_imm_sel(wb_imm_sel),
    .o_dout_v(dout_v), .o_busy(busy), .o_done(done), .o_state(state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [INST_W-1:0] exp_inst_q[$];
  logic [6:0]        exp_wb_q[$];   // {imm_sel, dst}
  logic [21:0]       exp_rf_q[$];   // {addr, data}
  logic [INST_W-1:0] pmem_m [16];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  int n_rf, n_inst, n_dout, n_done;
  int last_beat_cyc, first_inst_cyc, last_inst_cyc, first_dout_cyc, last_dout_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [21:0]       e_rf;
  logic [INST_W-1:0] e_inst;
  logic [6:0]        e_wb;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) begin
        n_rf++;
        last_beat_cyc = cyc;
        if (exp_rf_q.size() == 0) check("rf_unexpected", 32'(rf_we), 32'd0);
        else begin
          e_rf = exp_rf_q.pop_front();
          check("rf_write", 32'({rf_waddr, rf_wdata}), 32'(e_rf));
        end
      end
      if (inst_v) begin
        n_inst++;
        if (n_inst == 1) first_inst_cyc = cyc;
        last_inst_cyc = cyc;
        if (exp_inst_q.size() == 0) check("inst_unexpected", 32'(inst_v), 32'd0);
        else begin
          e_inst = exp_inst_q.pop_front();
          check("inst", 32'(inst), 32'(e_inst));
        end
      end
      if (dout_v) begin
        n_dout++;
        if (n_dout == 1) first_dout_cyc = cyc;
        last_dout_cyc = cyc;
        if (exp_wb_q.size() == 0) check("dout_unexpected", 32'(dout_v), 32'd0);
        else begin
          e_wb = exp_wb_q.pop_front();
          check("wb_tag", 32'({wb_imm_sel, wb_addr}), 32'(e_wb));
        end
      end
      if (done) n_done++;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic write_prog(input logic [PC_BITS-1:0] a, input logic [INST_W-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic stream(input int n, input bit rnd, input bit hold);
    for (int k = 0; k < n; k++) begin
      logic [15:0] v;
      bit acc;
      v = rnd ? 16'($urandom_range(0, 65535)) : 16'(k + 1);
      din = v;
      din_valid = 1'b1;
      exp_rf_q.push_back({6'(k), v});
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc = din_ready;
        @(posedge clk); #1;
        prog_we = 1'b0;
      end
      check("beat_accept", 32'(acc), 32'd1);
    end
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic start_run(input int len, input int nwords, input bit rnd, input bit hold);
    prog_len = 5'(len);
    for (int i = 0; i < len; i++) begin
      exp_inst_q.push_back(pmem_m[i]);
      exp_wb_q.push_back({pmem_m[i][23], pmem_m[i][17:12]});
    end
    n_rf = 0; n_inst = 0; n_dout = 0; n_done = 0;
    last_beat_cyc = 0; first_inst_cyc = 0; last_inst_cyc = 0;
    first_dout_cyc = 0; last_dout_cyc = 0;
    stream(nwords, rnd, hold);
  endtask

  task automatic finish_run(input int len);
    bit got;
    int dcyc;
    got = 1'b0;
    dcyc = 0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("din_ready_idle", 32'(din_ready), 32'd1);
    check("done_count", 32'(n_done), 32'd1);
    check("inst_v_count", 32'(n_inst), 32'(len));
    check("dout_v_count", 32'(n_dout), 32'(len));
    check("inst_q_left", 32'(exp_inst_q.size()), 32'd0);
    check("wb_q_left", 32'(exp_wb_q.size()), 32'd0);
    check("rf_q_left", 32'(exp_rf_q.size()), 32'd0);
    if (len > 0) begin
      check("first_inst_lat", 32'(first_inst_cyc), 32'(last_beat_cyc + 3));
      check("first_dout_lat", 32'(first_dout_cyc), 32'(first_inst_cyc + PIPE_LAT));
      check("last_dout_lat", 32'(last_dout_cyc), 32'(last_inst_cyc + PIPE_LAT));
      check("done_after_dout", 32'(dcyc), 32'(last_dout_cyc + 1));
    end else begin
      check("done_after_beat", 32'(dcyc), 32'(last_beat_cyc + 2));
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [INST_W-1:0] new_word;
    int k;
    bit hit;

    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_len = '0;
    din = '0; din_valid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_inst_v", 32'(inst_v), 32'd0);
    check("rst_dout_v", 32'(dout_v), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wb", 32'({wb_imm_sel, wb_addr}), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Chebyshev program in pmem[0..3], random filler above
    pmem_m[0] = {6'h02, 6'd0, 6'd1, 6'd2};
    pmem_m[1] = {6'h23, 6'd1, 6'd0, 6'd3};
    pmem_m[2] = {6'h05, 6'd2, 6'd1, 6'd0};
    pmem_m[3] = {6'h21, 6'd3, 6'd2, 6'd5};
    for (int i = 4; i < 16; i++) pmem_m[i] = 24'($urandom_range(0, 24'hFFFFFF));
    for (int i = 0; i < 16; i++) write_prog(4'(i), pmem_m[i]);

    // Run 1: 4 instructions, din = 1,2,3,4
    start_run(4, 4, 1'b0, 1'b0);
    finish_run(4);

    // Run 2: empty program, 2-word burst
    start_run(0, 2, 1'b1, 1'b0);
    finish_run(0);

    // Run 3: 70 beats offered, only 64 taken; full 16-instruction program
    start_run(16, 64, 1'b1, 1'b1);
    for (int j = 0; j < 6; j++) begin
      din = 16'($urandom_range(0, 65535));
      @(negedge clk);
      check("overflow_ready", 32'(din_ready), 32'd0);
      check("overflow_rf_we", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    check("overflow_writes", 32'(n_rf), 32'd64);
    finish_run(16);

    // Run 4: program write during EXEC is ignored
    start_run(4, 4, 1'b1, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk);
      if (state_dbg == 2'd2) hit = 1'b1;
    end
    check("exec_reached", 32'(hit), 32'd1);
    @(posedge clk); #1;
    write_prog(4'd2, pmem_m[2] ^ 24'hFFFFFF);
    finish_run(4);

    // Run 5: program write in IDLE together with the first beat
    new_word = {6'h27, 6'd2, 6'd3, 6'd1};
    pmem_m[2] = new_word;
    prog_we = 1'b1; prog_addr = 4'd2; prog_wdata = new_word;
    start_run(4, 4, 1'b1, 1'b0);
    finish_run(4);

    // Run 6: asynchronous reset at pc=2
    start_run(4, 4, 1'b1, 1'b0);
    k = 0;
    for (int t = 0; t < 20 && k < 2; t++) begin
      @(negedge clk);
      if (inst_v) k++;
    end
    check("rst_point_reached", 32'(k), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_inst_v", 32'(inst_v), 32'd0);
    check("midrst_dout_v", 32'(dout_v), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_din_ready", 32'(din_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_inst_q.delete();
    exp_wb_q.delete();
    exp_rf_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Runs 7 and 8: intact program after reset, then back-to-back
    start_run(4, 4, 1'b1, 1'b0);
    finish_run(4);
    start_run(4, 4, 1'b1, 1'b0);
    finish_run(4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
